// File: rtl/counter_gen.sv
// counter_gen: parametrised up/down counter with load, prescaled stepping,
// wrap or saturate at the boundaries, terminal-count pulse and sticky
// overflow flag. The default parameters give a plain 8-bit loadable
// start/stop counter.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MAX       highest count value, 1 .. 2**WIDTH-1
//   PRESCALE  enabled cycles per count step (>= 1)
//   SATURATE  0: wrap at the boundaries, 1: hold at the boundaries
//
// Ports
//   clk   clock, all state changes on the rising edge
//   clr   synchronous active-high clear, highest priority
//   l     synchronous load of d (clamped to MAX)
//   s_s   start/stop: 1 runs, 0 holds count and prescaler
//   up    direction: 1 up, 0 down, sampled at every step
//   d     load value
//   c     current count (registered)
//   tc    one-cycle pulse after each boundary step (registered)
//   ovf   sticky overflow/underflow flag, cleared only by clr

module counter_gen #(
   parameter int WIDTH    = 8,
   parameter int MAX      = 2**WIDTH-1,
   parameter int PRESCALE = 1,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             l,
   input  logic             s_s,
   input  logic             up,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] c,
   output logic             tc,
   output logic             ovf
);

   // A 1-bit prescaler is kept even when PRESCALE=1; it then sits at 0,
   // which is also its terminal value, so every enabled cycle is a step.
   localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] C_MAX   = WIDTH'(MAX);
   localparam logic [PW-1:0]    PC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]    pc;
   logic [PW-1:0]    pc_nxt;
   logic [WIDTH-1:0] c_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;
   logic             pc_done;
   logic             step;
   logic             at_top;
   logic             at_bot;
   logic             bnd_step;

   always_comb begin
      pc_done  = (pc == PC_LAST);
      step     = s_s && pc_done;
      at_top   = (c == C_MAX);
      at_bot   = (c == '0);
      // Boundary is detected by compare, never by relying on natural
      // WIDTH-bit rollover, so MAX=2**WIDTH-1 behaves like any other MAX.
      bnd_step = step && (up ? at_top : at_bot);

      c_nxt   = c;
      pc_nxt  = pc;
      tc_nxt  = 1'b0;
      ovf_nxt = ovf;

      if (l) begin
         // Load wins over a coinciding step and restarts the prescale period.
         c_nxt  = (d > C_MAX) ? C_MAX : d;
         pc_nxt = '0;
      end else begin
         if (s_s) begin
            pc_nxt = pc_done ? '0 : pc + 1'b1;
         end
         if (step) begin
            if (up) begin
               if (at_top) begin
                  c_nxt = SATURATE ? C_MAX : '0;
               end else begin
                  c_nxt = c + 1'b1;
               end
            end else begin
               if (at_bot) begin
                  c_nxt = SATURATE ? '0 : C_MAX;
               end else begin
                  c_nxt = c - 1'b1;
               end
            end
         end
         tc_nxt  = bnd_step;
         ovf_nxt = ovf | bnd_step;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         c   <= '0;
         pc  <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         c   <= c_nxt;
         pc  <= pc_nxt;
         tc  <= tc_nxt;
         ovf <= ovf_nxt;
      end
   end

endmodule

// File: doc/counter_gen.md
# counter_gen

Parametrised successor to the team's 8-bit loadable start/stop counter. Counts up or down between 0 and a programmable modulus MAX, with an optional clock-enable prescaler, wrap or saturate behaviour at the boundaries, a terminal-count pulse and a sticky overflow flag. Used wherever the design needs a timer, event counter or modulo-N sequencer. The plain 8-bit counter is the default configuration.

## Interface
Parameters:
- WIDTH, 8: counter width in bits (≥2).
- MAX, 2**WIDTH-1: highest count value; legal range 1..2**WIDTH-1.
- PRESCALE, 1: number of enabled cycles per count step (≥1).
- SATURATE, 0: 0 wraps at the boundaries; 1 holds at the boundaries.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  synchronous, active-high reset; highest priority.
- l  in  1  synchronous load of d.
- s_s  in  1  start/stop: 1 runs the counter, 0 holds it.
- up  in  1  direction: 1 counts up, 0 counts down; sampled at every step.
- d  in  WIDTH  load value.
- c  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered, one cycle per boundary step).
- ovf  out  1  sticky overflow/underflow flag.

## Operation
- Internal prescaler pc, range 0..PRESCALE-1. A step occurs in a cycle where s_s=1 and pc=PRESCALE-1. When PRESCALE=1, every cycle with s_s=1 is a step.
- pc increments while s_s=1 and wraps to 0 on a step. pc holds while s_s=0.
- Priority each cycle is clr > l > step > hold.
- clr: c=0, pc=0, tc=0, ovf=0. l and s_s are ignored in that cycle.
- l (without clr):
  - c = d if d ≤ MAX, otherwise c = MAX (clamped).
  - pc = 0, tc = 0, ovf unchanged.
  - A step that coincides with the load is discarded.
- Step with up=1:
  - c<MAX: c+1.
  - c=MAX: wraps to 0 (SATURATE=0) or holds at MAX (SATURATE=1). This is a boundary step.
- Step with up=0:
  - c>0: c-1.
  - c=0: wraps to MAX (SATURATE=0) or holds at 0 (SATURATE=1). This is a boundary step.
- tc=1 in the cycle after a boundary step, otherwise 0. In saturate mode, tc pulses on every step taken while held at the boundary.
- ovf is set by any boundary step and is cleared only by clr.
- Values of c above MAX are unreachable.
- Arithmetic is WIDTH bits and must not wrap naturally when MAX=2**WIDTH-1; boundary detection is by comparison with MAX or 0.

## Timing
- Reset values: c=0, tc=0, ovf=0, pc=0.
- Load latency: 1 cycle. The edge that samples l=1 updates c.
- Step latency: c changes on the edge that samples the step condition.
- After s_s rises with pc=0, the first step happens on the PRESCALE-th enabled edge. The steady-state step period is PRESCALE cycles.
- Pausing with s_s=0 keeps the partial prescale count: resuming finishes the remaining cycles and does not restart the count.
- tc and ovf assert on the same edge that applies the boundary step to c.
- A direction change takes effect at the next step; it does not change pc.
- clr or l in the middle of a prescale period discards the partial period.

## Test plan
- Default parameters:
  - Stimulus: clr for 1 cycle, then load d=8'hF0, then s_s=1 with up=1.
  - Required: c=F0 one cycle after the load; c counts F1..FF, then 00 on the 16th step; tc pulses exactly once, on the edge where c becomes 00; ovf=1 from then on.
- WIDTH=4, MAX=9, PRESCALE=4, SATURATE=0, up=1, continuous s_s:
  - Required: c steps every 4 cycles through 0..9 then 0 (40 cycles per wrap); tc pulses once per wrap.
  - Drop s_s for 3 cycles midway: c and pc hold, then resume with no lost or extra step.
- SATURATE=1, MAX=5, load d=2, up=0:
  - Required: c goes 1, 0, 0, 0; tc pulses on the 3rd and 4th steps; ovf=1.
  - Switch to up=1: c goes 1, 2, ….
- Load clamp, WIDTH=4, MAX=9:
  - Load d=4'hE: c=9.
  - Then one step up: c=0 with a tc pulse.
- Simultaneous events:
  - clr=1 with l=1 and s_s=1: c=0, ovf=0.
  - l=1 in the same cycle as a due step: c=d, no step applied, and the next step comes PRESCALE enabled cycles later.
- clr during a run: with c=7, pc=2 and ovf=1, one clr cycle gives all outputs 0. Counting restarts from 0 with a full prescale period.
